// File: rtl/dfm_pkg.sv
// Shared types and helpers for the frequency-meter core: result layout,
// measure FSM encoding and the debug view exported by dfm_core.
package dfm_pkg;

  localparam logic [7:0]  CMD_DATA_RD = 8'h3B;
  localparam logic [31:0] CNT_MAX     = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] sig_cnt;
    logic [31:0] ref_cnt;
  } dfm_result_t;

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    WRITE
  } meas_state_t;

  typedef struct packed {
    meas_state_t state;
    logic        rd_en;
    logic [2:0]  rd_addr;
  } dfm_dbg_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

  // Byte 0 is the most significant byte of the result.
  function automatic logic [7:0] result_byte(input dfm_result_t r, input logic [2:0] idx);
    logic [63:0] w;
    w = r >> {idx ^ 3'd7, 3'b000};
    return w[7:0];
  endfunction

endpackage

// File: rtl/dfm_if.sv
// Byte-level link between the SPI slave (master side) and dfm_core (slave side).
interface dfm_if;
  import dfm_pkg::*;

  // spi_byte_vld is a one-cycle strobe with no back-pressure: dc and
  // spi_byte_data are only meaningful in the strobe cycle. reg_rd_data is
  // always valid and follows the read pointer one cycle after each strobe.
  logic       dc;
  logic       spi_byte_vld;
  logic [7:0] spi_byte_data;
  logic [7:0] reg_rd_data;

  modport master (
    output dc,
    output spi_byte_vld,
    output spi_byte_data,
    input  reg_rd_data
  );

  modport slave (
    input  dc,
    input  spi_byte_vld,
    input  spi_byte_data,
    output reg_rd_data
  );

endinterface

// File: rtl/dfm_sync_edge.sv
// Two-flop synchronizer for the measured signal plus a third flop that
// turns each rising edge into a single-cycle pulse in the clk_i domain.
module dfm_sync_edge (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic edge_o
);

  logic sync_1;
  logic sync_2;
  logic sync_3;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sync_3 <= 1'b0;
    end else begin
      sync_1 <= async_i;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
    end
  end

  assign edge_o = sync_2 & ~sync_3;

endmodule

// File: rtl/dfm_core.sv
// Frequency-meter core: gated edge/clock counting, a 64-bit result register
// and a byte-serial read port driven by SPI command/data bytes.
module dfm_core
  import dfm_pkg::*;
#(
  parameter int GATE_CYCLES = 20000
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  logic     sig_clk_i,
  dfm_if.slave     spi,
  output dfm_dbg_t dbg_o
);

  logic        sig_edge;
  meas_state_t state;
  logic [31:0] ref_cnt;
  logic [31:0] sig_cnt;
  logic [31:0] gate_cnt;
  logic        gate_done;
  dfm_result_t result;
  logic        rd_en;
  logic [2:0]  rd_addr;

  dfm_sync_edge u_sync_edge (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .async_i (sig_clk_i),
    .edge_o  (sig_edge)
  );

  assign gate_done = (gate_cnt >= 32'(GATE_CYCLES));

  // gate_cnt stops at the threshold so a missing signal can never wrap it.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      ref_cnt  <= '0;
      sig_cnt  <= '0;
      gate_cnt <= '0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sig_edge) begin
            state    <= OPEN;
            ref_cnt  <= '0;
            sig_cnt  <= '0;
            gate_cnt <= '0;
          end
        end
        OPEN: begin
          ref_cnt <= sat_inc(ref_cnt);
          if (!gate_done) gate_cnt <= gate_cnt + 32'd1;
          if (sig_edge) begin
            sig_cnt <= sat_inc(sig_cnt);
            if (gate_done) state <= WRITE;
          end
        end
        WRITE: begin
          state <= IDLE;
          // A snapshot being read out is frozen; this result is dropped.
          if (!rd_en) result <= '{sig_cnt: sig_cnt, ref_cnt: ref_cnt};
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else if (spi.spi_byte_vld) begin
      if (!spi.dc) begin
        rd_en   <= (spi.spi_byte_data == CMD_DATA_RD);
        rd_addr <= '0;
      end else if (rd_en) begin
        if (rd_addr == 3'd7) begin
          rd_en   <= 1'b0;
          rd_addr <= '0;
        end else begin
          rd_addr <= rd_addr + 3'd1;
        end
      end
    end
  end

  assign spi.reg_rd_data = result_byte(result, rd_addr);
  assign dbg_o           = '{state: state, rd_en: rd_en, rd_addr: rd_addr};

endmodule

// File: tb/tb_dfm_core.sv
// Bench for dfm_core: control table, gated measurements against an
// edge-timestamp model, snapshot freeze, command abort and no-signal cases.
module tb_dfm_core;
  import dfm_pkg::*;

  localparam int G = 1000;

  typedef struct {
    logic       dc;
    logic [7:0] data;
    logic       exp_en;
    logic [2:0] exp_addr;
  } vec_t;

  logic     clk     = 1'b0;
  logic     rst_n   = 1'b0;
  logic     sig_clk = 1'b0;
  dfm_dbg_t dbg;

  dfm_if spi_bus ();

  dfm_core #(.GATE_CYCLES(G)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .sig_clk_i (sig_clk),
    .spi       (spi_bus.slave),
    .dbg_o     (dbg)
  );

  int          n_chk   = 0;
  int          n_fail  = 0;
  int          n_wr    = 0;
  int          acc_idx = -1;
  bit          tb_rd_active = 1'b0;
  int          tb_addr = 0;
  bit          sig_on  = 1'b0;
  int          half_ps = 250000;
  longint      cyc     = 0;
  longint      edge_q[$];
  int unsigned pred_sig[$];
  int unsigned pred_ref[$];
  vec_t        tbl[17];

  // ---------------- clock / reset / signal source ----------------
  initial forever #2.4ns clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Half-ns offset keeps signal edges off the clock edges.
  initial begin : sig_gen
    #0.5ns;
    forever begin
      if (sig_on) begin
        sig_clk = 1'b1;
        edge_q.push_back(cyc);
        #(half_ps * 1ps);
        sig_clk = 1'b0;
        #(half_ps * 1ps);
      end else begin
        #1ns;
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Writes are accepted only while no read session is open.
  always @(negedge clk) begin
    if (rst_n && dbg.state == WRITE) begin
      n_wr++;
      if (!tb_rd_active) acc_idx = n_wr - 1;
    end
  end

  // ---------------- reference model ----------------
  // A gate opens at an edge, closes at the first later edge at least G+1
  // cycles on, and the edge after the closing one opens the next gate.
  function automatic void build_pred();
    int idx;
    int j;
    pred_sig.delete();
    pred_ref.delete();
    idx = 0;
    while (idx < edge_q.size()) begin
      j = idx + 1;
      while (j < edge_q.size() && (edge_q[j] - edge_q[idx]) < G + 1) j++;
      if (j >= edge_q.size()) break;
      pred_sig.push_back(j - idx);
      pred_ref.push_back(int'(edge_q[j] - edge_q[idx]));
      idx = j + 1;
    end
  endfunction

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic get_expected(output logic [31:0] es, output logic [31:0] er);
    es = '0;
    er = '0;
    if (acc_idx >= 0) begin
      build_pred();
      chk("model_has_write", acc_idx < pred_sig.size(), pred_sig.size(), acc_idx + 1);
      if (acc_idx < pred_sig.size()) begin
        es = pred_sig[acc_idx];
        er = pred_ref[acc_idx];
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic dc, input logic [7:0] data, input int gap);
    @(negedge clk);
    spi_bus.dc            = dc;
    spi_bus.spi_byte_data = data;
    spi_bus.spi_byte_vld  = 1'b1;
    @(posedge clk);
    #1ns;
    spi_bus.spi_byte_vld  = 1'b0;
    if (!dc) begin
      tb_rd_active = (data == CMD_DATA_RD);
      tb_addr      = 0;
    end else if (tb_rd_active) begin
      if (tb_addr == 7) begin
        tb_addr      = 0;
        tb_rd_active = 1'b0;
      end else begin
        tb_addr++;
      end
    end
    repeat (gap) @(posedge clk);
  endtask

  task automatic wait_wr(input int target, input int budget, input string name);
    int k = 0;
    while (n_wr < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk(name, n_wr >= target, n_wr, target);
  endtask

  task automatic stop_sig();
    sig_on = 1'b0;
    repeat (G + 20) @(posedge clk);
  endtask

  task automatic start_sig(input int period_ns);
    half_ps = period_ns * 500;
    sig_on  = 1'b1;
  endtask

  function automatic int pick_period();
    int p, n, m;
    do begin
      p = $urandom_range(150, 900);
      n = (4805 + p - 1) / p;
      m = n * p - 4805;
    end while (m < 20 || p - m < 20);
    return p;
  endfunction

  // Full 8-byte read; optionally waits for a measurement write after pause_at bytes.
  task automatic read_and_check(input string name, input int pause_at, output logic [63:0] got);
    logic [31:0] es, er;
    got = '0;
    send_byte(1'b0, CMD_DATA_RD, $urandom_range(1, 6));
    get_expected(es, er);
    for (int i = 0; i < 8; i++) begin
      if (i == pause_at) wait_wr(n_wr + 1, 2500, {name, "_write_during_read"});
      @(negedge clk);
      got = {got[55:0], spi_bus.reg_rd_data};
      send_byte(1'b1, 8'($urandom_range(0, 255)), $urandom_range(1, 10));
    end
    @(negedge clk);
    chk({name, "_rd_en_drop"}, dbg.rd_en == 1'b0, dbg.rd_en, 0);
    chk({name, "_sig_cnt"}, got[63:32] == es, got[63:32], es);
    chk({name, "_ref_cnt"}, (got[31:0] + 32'd1 >= er) && (got[31:0] <= er + 32'd1), got[31:0], er);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [63:0] got;
    int          n0;
    int          p;
    logic [31:0] es, er;

    tbl[0]  = '{1'b1, 8'h55, 1'b0, 3'd0};
    tbl[1]  = '{1'b0, 8'h3B, 1'b1, 3'd0};
    tbl[2]  = '{1'b1, 8'hA0, 1'b1, 3'd1};
    tbl[3]  = '{1'b1, 8'hA1, 1'b1, 3'd2};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 3'd0};
    tbl[5]  = '{1'b1, 8'hA2, 1'b0, 3'd0};
    tbl[6]  = '{1'b0, 8'h3B, 1'b1, 3'd0};
    tbl[7]  = '{1'b1, 8'h01, 1'b1, 3'd1};
    tbl[8]  = '{1'b1, 8'h02, 1'b1, 3'd2};
    tbl[9]  = '{1'b1, 8'h03, 1'b1, 3'd3};
    tbl[10] = '{1'b1, 8'h04, 1'b1, 3'd4};
    tbl[11] = '{1'b1, 8'h05, 1'b1, 3'd5};
    tbl[12] = '{1'b1, 8'h06, 1'b1, 3'd6};
    tbl[13] = '{1'b1, 8'h07, 1'b1, 3'd7};
    tbl[14] = '{1'b1, 8'h08, 1'b0, 3'd0};
    tbl[15] = '{1'b1, 8'h09, 1'b0, 3'd0};
    tbl[16] = '{1'b0, 8'h3A, 1'b0, 3'd0};

    spi_bus.dc            = 1'b0;
    spi_bus.spi_byte_vld  = 1'b0;
    spi_bus.spi_byte_data = 8'h00;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rd_data", spi_bus.reg_rd_data == 8'h00, spi_bus.reg_rd_data, 0);
    chk("reset_state", dbg.state == IDLE, dbg.state, IDLE);
    chk("reset_rd_en", dbg.rd_en == 1'b0, dbg.rd_en, 0);
    chk("reset_rd_addr", dbg.rd_addr == 3'd0, dbg.rd_addr, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      send_byte(tbl[i].dc, tbl[i].data, 1);
      @(negedge clk);
      chk($sformatf("tbl%0d_rd_en", i), dbg.rd_en == tbl[i].exp_en, dbg.rd_en, tbl[i].exp_en);
      chk($sformatf("tbl%0d_rd_addr", i), dbg.rd_addr == tbl[i].exp_addr, dbg.rd_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_rd_data", i), spi_bus.reg_rd_data == 8'h00, spi_bus.reg_rd_data, 0);
    end

    read_and_check("zero_read", 8, got);
    chk("zero_read_all", got == 64'h0, got, 0);

    // 500 ns signal: 10 edges close a 4800 ns gate, about 1042 clocks.
    start_sig(500);
    wait_wr(1, 4000, "first_write");
    read_and_check("meas500", 8, got);
    chk("meas500_sig_is_10", got[63:32] == 32'd10, got[63:32], 10);
    chk("meas500_ref_near_1042", got[31:0] >= 32'd1041 && got[31:0] <= 32'd1043, got[31:0], 1042);

    // Switch to 350 ns, then freeze a snapshot across a write.
    stop_sig();
    start_sig(350);
    wait_wr(n_wr + 1, 4000, "restart_write");
    read_and_check("freeze", 3, got);
    wait_wr(n_wr + 1, 2500, "post_freeze_write");
    read_and_check("after_freeze", 8, got);
    chk("after_freeze_sig_is_14", got[63:32] == 32'd14, got[63:32], 14);

    // Non-read command aborts the session and data strobes stop advancing.
    send_byte(1'b0, CMD_DATA_RD, 2);
    send_byte(1'b1, 8'h11, 2);
    send_byte(1'b1, 8'h22, 2);
    send_byte(1'b0, 8'h00, 2);
    @(negedge clk);
    chk("abort_rd_en", dbg.rd_en == 1'b0, dbg.rd_en, 0);
    chk("abort_rd_addr", dbg.rd_addr == 3'd0, dbg.rd_addr, 0);
    send_byte(1'b1, 8'h33, 2);
    send_byte(1'b1, 8'h44, 2);
    @(negedge clk);
    get_expected(es, er);
    chk("abort_ignored_addr", dbg.rd_addr == 3'd0, dbg.rd_addr, 0);
    chk("abort_byte0", spi_bus.reg_rd_data == es[31:24], spi_bus.reg_rd_data, es[31:24]);

    // No signal: nothing may be written for ten gate lengths.
    stop_sig();
    n0 = n_wr;
    repeat (10 * G) @(posedge clk);
    chk("no_signal_no_write", n_wr == n0, n_wr, n0);
    read_and_check("no_signal", 8, got);

    // Randomized periods with random aborts.
    for (int r = 0; r < 3; r++) begin
      p = pick_period();
      n0 = n_wr;
      start_sig(p);
      wait_wr(n0 + 3, 6000, $sformatf("rand%0d_writes", r));
      read_and_check($sformatf("rand%0d_p%0d", r, p), 8, got);
      if ($urandom_range(0, 1) == 1) begin
        send_byte(1'b0, CMD_DATA_RD, 1);
        repeat ($urandom_range(1, 6)) send_byte(1'b1, 8'($urandom_range(0, 255)), 1);
        send_byte(1'b0, 8'($urandom_range(0, 58)), 1);
        @(negedge clk);
        chk($sformatf("rand%0d_abort_rd_en", r), dbg.rd_en == 1'b0, dbg.rd_en, 0);
        chk($sformatf("rand%0d_abort_rd_addr", r), dbg.rd_addr == 3'd0, dbg.rd_addr, 0);
      end
      stop_sig();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
